idex_hazard_ctrl: RTL
=====================

Name: idex_hazard_ctrl

Overview:
Hazard and sequencing controller for the IF/ID and ID/EX pipeline registers of the 8-bit ARM/RISC-V hybrid core. It detects load-use hazards, taken-branch redirects and data-memory wait states. It drives stall, flush and PC-redirect controls so those registers hold, bubble or clear on the correct nclk edge. It also keeps saturating performance counters for stall cycles and branch flushes.

Parameters:
LOAD_LAT, 1, bubble cycles inserted per load-use hazard (1..7)
BR_PENALTY, 1, extra IF/ID flush cycles after a taken-branch redirect (0..3)

Ports:
nclk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous active-high reset
id_valid  in  1  ID stage holds a real instruction
id_src1  in  4  ID source register 1
id_src1_used  in  1  src1 is actually read
id_src2  in  4  ID source register 2
id_src2_used  in  1  src2 is actually read
ex_valid  in  1  EX stage holds a real instruction (not a bubble)
ex_reg_dest  in  4  EX destination register
ex_reg_write  in  1  EX instruction writes a register
ex_rd_en  in  1  EX instruction is a memory load
ex_branch_taken  in  1  EX resolved a taken branch (ARM condition met or riscv_branch)
ex_branch_target  in  8  resolved branch target PC
mem_busy  in  1  data memory not ready; whole pipeline must freeze
pc_stall  out  1  hold PC
ifid_stall  out  1  hold IF/ID register
ifid_flush  out  1  clear IF/ID register to a bubble
idex_stall  out  1  hold ID/EX register
idex_flush  out  1  load a bubble (all zeros) into ID/EX
pc_load  out  1  load PC from pc_target on the next edge
pc_target  out  8  redirect address
stall_cycles  out  8  saturating count of cycles with pc_stall=1
flush_events  out  8  saturating count of branch redirects
state  out  2  FSM state, for debug: 0 RUN, 1 LOAD_STALL, 2 BR_FLUSH

Behaviour:
- Control outputs are combinational from state and inputs, so they act on the same edge. Counters and the FSM are registered on posedge nclk.
- While rst=1: state=RUN, internal counter=0, stall_cycles=0, flush_events=0. All control outputs are forced to 0 and pc_target=0.
- Hazard term: lu = ex_valid & ex_rd_en & ex_reg_write & id_valid & ((id_src1_used & id_src1==ex_reg_dest) | (id_src2_used & id_src2==ex_reg_dest)). All 16 registers are checked; there is no hard-wired zero register.
- Branch term: br = ex_valid & ex_branch_taken.
- Priority, highest first: mem_busy, br, lu, state actions.
- mem_busy=1, in any state:
  - Outputs: pc_stall, ifid_stall and idex_stall all 1; all flushes 0; pc_load=0.
  - FSM state and the internal counter are frozen.
  - br and lu are ignored in that cycle.
  - stall_cycles increments.
- br, any state, mem_busy=0:
  - Outputs: pc_load=1, pc_target=ex_branch_target, ifid_flush=1, idex_flush=1, all stalls 0.
  - flush_events increments.
  - Next state: BR_FLUSH with cnt=BR_PENALTY if BR_PENALTY>0, else RUN.
  - A pending LOAD_STALL is aborted.
- RUN:
  - lu=1: pc_stall=1, ifid_stall=1, idex_flush=1. Next state LOAD_STALL with cnt=LOAD_LAT-1 if LOAD_LAT>1, else stay RUN.
  - Otherwise all control outputs are 0.
- LOAD_STALL: pc_stall=1, ifid_stall=1, idex_flush=1. cnt decrements each cycle; the cycle with cnt==1 returns to RUN.
- BR_FLUSH: ifid_flush=1, idex_flush=1, no stalls. cnt decrements each cycle; the cycle with cnt==1 returns to RUN.
- pc_target=0 whenever pc_load=0.
- The invalid state encoding 3 returns to RUN on the next edge with all control outputs 0.
- idex_stall and idex_flush are never both 1. ifid_stall and ifid_flush are never both 1; flush wins by construction.
- stall_cycles increments on every edge where pc_stall=1. Both counters saturate at 255 with no wrap.

Test Plan:
- Reset mid-stall: trigger lu with LOAD_LAT=3; assert rst in the 2nd stall cycle. State=0, all outputs 0 and counters 0 immediately (asynchronous).
- Load-use: EX load to r5 with ID src2=r5 used, LOAD_LAT=1. Exactly 1 cycle of pc_stall=ifid_stall=idex_flush=1, then RUN; stall_cycles=1. Same case with id_src2_used=0: no stall.
- Taken branch: ex_branch_taken=1, target=0x3C, BR_PENALTY=1. Cycle 0: pc_load=1, pc_target=0x3C, both flushes 1. Cycle 1: both flushes 1, no pc_load. Cycle 2: RUN. flush_events=1.
- Simultaneous br and lu: branch wins. No stall asserted; stall_cycles unchanged; state goes to BR_FLUSH.
- mem_busy: assert for 4 cycles during LOAD_STALL with LOAD_LAT=2. All stalls 1 and no flushes for those 4 cycles; LOAD_STALL resumes with its remaining count; stall_cycles=6.
- Saturation: hold mem_busy for 300 cycles. stall_cycles stays at 255.

Source files
------------

// File: rtl/idex_hazard_ctrl.sv
// Hazard/sequencing controller for the IF/ID and ID/EX pipeline registers.
// Handles load-use bubbles, taken-branch redirects and data-memory freezes, and counts stall and flush events.
module idex_hazard_ctrl #(
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned BR_PENALTY = 1
) (
  input  logic       nclk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [3:0] id_src1,
  input  logic       id_src1_used,
  input  logic [3:0] id_src2,
  input  logic       id_src2_used,
  input  logic       ex_valid,
  input  logic [3:0] ex_reg_dest,
  input  logic       ex_reg_write,
  input  logic       ex_rd_en,
  input  logic       ex_branch_taken,
  input  logic [7:0] ex_branch_target,
  input  logic       mem_busy,
  output logic       pc_stall,
  output logic       ifid_stall,
  output logic       ifid_flush,
  output logic       idex_stall,
  output logic       idex_flush,
  output logic       pc_load,
  output logic [7:0] pc_target,
  output logic [7:0] stall_cycles,
  output logic [7:0] flush_events,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    BR_FLUSH   = 2'd2
  } state_t;

  localparam logic [2:0] LOAD_CNT = 3'(LOAD_LAT - 1);
  localparam logic [2:0] BR_CNT   = 3'(BR_PENALTY);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       lu, br;

  assign lu = ex_valid & ex_rd_en & ex_reg_write & id_valid &
              ((id_src1_used & (id_src1 == ex_reg_dest)) |
               (id_src2_used & (id_src2 == ex_reg_dest)));
  assign br = ex_valid & ex_branch_taken;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_stall   = 1'b0;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    idex_stall = 1'b0;
    idex_flush = 1'b0;
    pc_load    = 1'b0;
    if (!rst) begin
      if (mem_busy) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_stall = 1'b1;
      end else if (br) begin
        pc_load    = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (BR_PENALTY > 0) begin
          state_d = BR_FLUSH;
          cnt_d   = BR_CNT;
        end else begin
          state_d = RUN;
        end
      end else begin
        unique case (state_q)
          RUN: begin
            if (lu) begin
              pc_stall   = 1'b1;
              ifid_stall = 1'b1;
              idex_flush = 1'b1;
              if (LOAD_LAT > 1) begin
                state_d = LOAD_STALL;
                cnt_d   = LOAD_CNT;
              end
            end
          end
          LOAD_STALL: begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
            cnt_d      = cnt_q - 3'd1;
            if (cnt_q == 3'd1) state_d = RUN;
          end
          BR_FLUSH: begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            cnt_d      = cnt_q - 3'd1;
            if (cnt_q == 3'd1) state_d = RUN;
          end
          default: state_d = RUN;
        endcase
      end
    end
    pc_target = pc_load ? ex_branch_target : 8'h00;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge nclk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      cnt_q        <= 3'd0;
      stall_cycles <= 8'd0;
      flush_events <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (pc_stall && stall_cycles != 8'hFF) stall_cycles <= stall_cycles + 8'd1;
      if (br && !mem_busy && flush_events != 8'hFF) flush_events <= flush_events + 8'd1;
    end
  end

  assign state = state_q;

endmodule
